// File: rtl/regfile_dbg_pkg.sv
// regfile_dbg_pkg: shared constants, state encoding and count normalisation for the register dump reader
package regfile_dbg_pkg;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    function automatic logic [CNT_W-1:0] norm_count(input logic [CNT_W-1:0] cnt);
        return (cnt == '0 || cnt > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : cnt;
    endfunction
endpackage

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a window of the register file read port and streams (register, data) bytes over valid/ready
module regfile_dump_reader
    import regfile_dbg_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Dump_Start,
    input  logic [ADDR_W-1:0] Start_Reg_Num,
    input  logic [CNT_W-1:0]  Dump_Count,
    output logic [ADDR_W-1:0] Read_Reg_Num,
    input  logic [DATA_W-1:0] Read_Data,
    output logic [ADDR_W-1:0] Tx_Addr,
    output logic [DATA_W-1:0] Tx_Data,
    output logic              Tx_Valid,
    input  logic              Tx_Ready,
    output logic              Dump_Busy,
    output logic              Dump_Done
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] index, index_inc;
    logic [CNT_W-1:0]  remaining;
    logic              xfer;

    assign xfer         = (state == SEND) && Tx_Ready;
    assign index_inc    = (index == ADDR_W'(NUM_REGS - 1)) ? '0 : index + 1'b1;
    assign Read_Reg_Num = (state == FETCH) ? index : '0;
    assign Tx_Valid     = state == SEND;
    assign Dump_Busy    = state != IDLE;
    assign Dump_Done    = state == DONE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = Dump_Start ? FETCH : IDLE;
            FETCH:   state_nxt = SEND;
            SEND:    state_nxt = !Tx_Ready ? SEND : (remaining == CNT_W'(1)) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            index     <= '0;
            remaining <= '0;
            Tx_Addr   <= '0;
            Tx_Data   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && Dump_Start) begin
                index     <= Start_Reg_Num;
                remaining <= norm_count(Dump_Count);
            end
            // read data is captured only here, so later writebacks never alter a byte in flight
            if (state == FETCH) begin
                Tx_Data <= Read_Data;
                Tx_Addr <= index;
            end
            if (xfer) begin
                remaining <= remaining - 1'b1;
                if (remaining != CNT_W'(1))
                    index <= index_inc;
            end
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: scoreboard bench for the register dump reader with a behavioural register file
module tb_regfile_dump_reader;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Dump_Start;
    logic [2:0] Start_Reg_Num;
    logic [3:0] Dump_Count;
    logic [2:0] Read_Reg_Num;
    logic [7:0] Read_Data;
    logic [2:0] Tx_Addr;
    logic [7:0] Tx_Data;
    logic       Tx_Valid;
    logic       Tx_Ready;
    logic       Dump_Busy;
    logic       Dump_Done;

    logic [7:0]  regs [8];
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [10:0] exp_q [$];
    logic [10:0] obs_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (wr_en) regs[wr_addr] <= wr_data;
    assign Read_Data = regs[Read_Reg_Num];

    regfile_dump_reader dut (
        .Clk(Clk), .Reset_n(Reset_n), .Dump_Start(Dump_Start), .Start_Reg_Num(Start_Reg_Num),
        .Dump_Count(Dump_Count), .Read_Reg_Num(Read_Reg_Num), .Read_Data(Read_Data),
        .Tx_Addr(Tx_Addr), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_Ready(Tx_Ready),
        .Dump_Busy(Dump_Busy), .Dump_Done(Dump_Done)
    );

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge Clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge Clk);
        wr_en = 1'b0;
    endtask

    task automatic start_dump(input logic [2:0] s, input logic [3:0] c);
        int n;
        logic [2:0] a;
        n = (c == 0 || c > 8) ? 8 : int'(c);
        for (int i = 0; i < n; i++) begin
            a = s + 3'(i);
            exp_q.push_back({a, regs[a]});
        end
        @(negedge Clk);
        Dump_Start = 1'b1; Start_Reg_Num = s; Dump_Count = c;
    endtask

    task automatic collect(input int poke, output int busy, output int dones, output int first_v, output bit tmo);
        busy = 0; dones = 0; first_v = 0; tmo = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            Dump_Start = 1'b0;
            if (!Dump_Busy) begin
                tmo = 1'b0;
                break;
            end
            busy++;
            if (Tx_Valid && first_v == 0) first_v = busy;
            if (Tx_Valid && Tx_Ready) obs_q.push_back({Tx_Addr, Tx_Data});
            if (Dump_Done) dones++;
            if (busy == poke) begin
                Dump_Start = 1'b1; Start_Reg_Num = 3'd5; Dump_Count = 4'd2;
            end
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Dump_Start = 1'b0; Start_Reg_Num = '0; Dump_Count = '0;
        Tx_Ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Tx_Valid, Dump_Busy, Dump_Done, Tx_Addr, Tx_Data, Read_Reg_Num} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {Tx_Valid, Dump_Busy, Dump_Done, Tx_Addr, Tx_Data, Read_Reg_Num});
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 8; i++) write_reg(3'(i), 8'(i));
    endtask

    task automatic test_full_dump;
        int busy, dones, fv;
        bit tmo;
        logic [10:0] e, o;
        start_dump(3'd0, 4'd0);
        collect(0, busy, dones, fv, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL full_timeout: dump never returned to idle"); end
        checks++;
        if (busy + 1 !== 18) begin errors++; $display("FAIL full_cycles: got %0d expected 18", busy + 1); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL full_done: got %0d pulses expected 1", dones); end
        checks++;
        if (fv !== 2) begin errors++; $display("FAIL full_latency: first valid in busy cycle %0d expected 2", fv); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL full_count: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL full_byte: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wrap;
        int busy, dones, fv;
        bit tmo;
        logic [10:0] e, o;
        start_dump(3'd6, 4'd4);
        collect(0, busy, dones, fv, tmo);
        checks++;
        if (tmo || dones !== 1 || busy !== 9) begin
            errors++; $display("FAIL wrap_done: got tmo=%0d dones=%0d busy=%0d expected 0/1/9", tmo, dones, busy);
        end
        checks++;
        if (obs_q.size() !== 4) begin errors++; $display("FAIL wrap_count: got %0d bytes expected 4", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL wrap_byte: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure;
        int stall;
        bit tmo;
        logic [10:0] e, o;
        write_reg(3'd2, 8'h2A);
        start_dump(3'd0, 4'd4);
        stall = 0; tmo = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            Dump_Start = 1'b0;
            if (!Dump_Busy) begin tmo = 1'b0; break; end
            if (Tx_Valid && !Tx_Ready) begin
                if (stall == 5) Tx_Ready = 1'b1;
                else begin
                    stall++; checks++;
                    if (Tx_Addr !== 3'd2 || Tx_Data !== 8'h2A) begin
                        errors++; $display("FAIL bp_hold: got addr %0d data %h expected 2 2a", Tx_Addr, Tx_Data);
                    end
                end
            end else if (!Tx_Valid && Read_Reg_Num == 3'd2) Tx_Ready = 1'b0;
            if (Tx_Valid && Tx_Ready) obs_q.push_back({Tx_Addr, Tx_Data});
        end
        Tx_Ready = 1'b1;
        checks++;
        if (tmo || stall !== 5) begin errors++; $display("FAIL bp_stall: got tmo=%0d stall=%0d expected 0/5", tmo, stall); end
        checks++;
        if (obs_q.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d bytes expected 4", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL bp_byte: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_count_clamp;
        int busy, dones, fv;
        bit tmo;
        logic [10:0] e, o;
        start_dump(3'd0, 4'd12);
        collect(6, busy, dones, fv, tmo);
        checks++;
        if (tmo || dones !== 1 || busy !== 17) begin
            errors++; $display("FAIL clamp_done: got tmo=%0d dones=%0d busy=%0d expected 0/1/17", tmo, dones, busy);
        end
        checks++;
        if (obs_q.size() !== 8) begin errors++; $display("FAIL clamp_count: got %0d bytes expected 8", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL clamp_byte: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        start_dump(3'd1, 4'd3);
        collect(7, busy, dones, fv, tmo);
        @(negedge Clk);
        checks++;
        if (Dump_Busy !== 1'b0) begin errors++; $display("FAIL start_in_done: busy got %b expected 0", Dump_Busy); end
        checks++;
        if (tmo || dones !== 1 || obs_q.size() !== 3) begin
            errors++; $display("FAIL short_dump: got tmo=%0d dones=%0d bytes=%0d expected 0/1/3", tmo, dones, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL short_byte: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_dump;
        int busy, dones, fv;
        bit tmo, hit;
        logic [10:0] e, o;
        start_dump(3'd0, 4'd0);
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge Clk);
            Dump_Start = 1'b0;
            if (Tx_Valid && Tx_Addr == 3'd2) begin
                Reset_n = 1'b0; hit = 1'b1;
                #1;
                checks++;
                if (Tx_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", Tx_Valid); end
                checks++;
                if ({Dump_Busy, Dump_Done, Tx_Addr, Tx_Data, Read_Reg_Num} !== 16'd0) begin
                    errors++; $display("FAIL rst_outputs: got %h expected 0", {Dump_Busy, Dump_Done, Tx_Addr, Tx_Data, Read_Reg_Num});
                end
                break;
            end
            if (Tx_Valid && Tx_Ready) obs_q.push_back({Tx_Addr, Tx_Data});
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rst_reach: third byte never presented"); end
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rst_pre_byte: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (Dump_Done !== 1'b0 || Dump_Busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_done: got done=%b busy=%b expected 0/0", Dump_Done, Dump_Busy);
        end
        start_dump(3'd0, 4'd0);
        collect(0, busy, dones, fv, tmo);
        checks++;
        if (tmo || dones !== 1 || obs_q.size() !== 8) begin
            errors++; $display("FAIL rst_redump: got tmo=%0d dones=%0d bytes=%0d expected 0/1/8", tmo, dones, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rst_redump_byte: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_concurrent_write;
        int busy, dones, fv;
        bit tmo;
        logic [10:0] e;
        start_dump(3'd4, 4'd1);
        @(negedge Clk);
        Dump_Start = 1'b0;
        checks++;
        if (Read_Reg_Num !== 3'd4) begin errors++; $display("FAIL cw_fetch_addr: got %0d expected 4", Read_Reg_Num); end
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h55;
        @(negedge Clk);
        wr_en = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!Tx_Valid || {Tx_Addr, Tx_Data} !== e || e !== {3'd4, 8'h04}) begin
            errors++; $display("FAIL cw_old_value: got valid=%b byte %h expected 1 %h", Tx_Valid, {Tx_Addr, Tx_Data}, {3'd4, 8'h04});
        end
        collect(0, busy, dones, fv, tmo);
        checks++;
        if (tmo || dones !== 1) begin errors++; $display("FAIL cw_done: got tmo=%0d dones=%0d expected 0/1", tmo, dones); end
        exp_q.delete(); obs_q.delete();
        start_dump(3'd4, 4'd1);
        collect(0, busy, dones, fv, tmo);
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== {3'd4, 8'h55}) begin
            errors++; $display("FAIL cw_new_value: got %0d bytes first %h expected 1 %h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 11'h0, {3'd4, 8'h55});
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_wrap();
        test_backpressure();
        test_count_clamp();
        test_reset_mid_dump();
        test_concurrent_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
